// File: rtl/ars_mixcol_arbiter.sv
// Two-requester round-robin arbiter in front of one shared MixColumns unit.
// Owns the unit's operand/mode for a whole operation and returns ack/err/result per requester.
module ars_mixcol_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_i,
  input  logic         req1_i,
  input  logic         dec0_i,
  input  logic         dec1_i,
  input  logic [127:0] data0_i,
  input  logic [127:0] data1_i,
  output logic         ack0_o,
  output logic         ack1_o,
  output logic         err0_o,
  output logic         err1_o,
  output logic [127:0] res0_o,
  output logic [127:0] res1_o,
  output logic         busy_o,
  output logic         mc_start_o,
  output logic         mc_decrypt_o,
  output logic [127:0] mc_data_o,
  input  logic         mc_ready_i,
  input  logic [127:0] mc_data_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic         owner_q, owner_d;
  logic         lastServed_q, lastServed_d;
  logic         mode_q, mode_d;
  logic         errFlag_q, errFlag_d;
  logic [2:0]   waitCnt_q, waitCnt_d;
  logic [127:0] operand_q, operand_d;
  logic [127:0] res0_q, res0_d;
  logic [127:0] res1_q, res1_d;
  logic         anyReq;
  logic         grantSel;

  assign anyReq = req0_i | req1_i;
  // On a tie the requester that was not served last wins; a sole requester always wins.
  assign grantSel = (req0_i & req1_i) ? ~lastServed_q : req1_i;

  assign busy_o       = (state_q != IDLE);
  assign mc_data_o    = operand_q;
  assign mc_decrypt_o = mode_q;
  assign res0_o       = res0_q;
  assign res1_o       = res1_q;

  // Next-state and strobe logic; ready outside WAIT is simply never looked at.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lastServed_d = lastServed_q;
    mode_d       = mode_q;
    errFlag_d    = errFlag_q;
    waitCnt_d    = waitCnt_q;
    operand_d    = operand_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    ack0_o       = 1'b0;
    ack1_o       = 1'b0;
    err0_o       = 1'b0;
    err1_o       = 1'b0;
    mc_start_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          owner_d   = grantSel;
          operand_d = grantSel ? data1_i : data0_i;
          mode_d    = grantSel ? dec1_i : dec0_i;
          state_d   = START;
        end
      end
      START: begin
        mc_start_o = 1'b1;
        waitCnt_d  = 3'd0;
        state_d    = WAIT;
      end
      WAIT: begin
        waitCnt_d = waitCnt_q + 3'd1;
        if (mc_ready_i) begin
          errFlag_d = 1'b0;
          if (owner_q) res1_d = mc_data_i;
          else         res0_d = mc_data_i;
          state_d = DONE;
        end else if (waitCnt_q == 3'd7) begin
          errFlag_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        ack0_o       = ~owner_q;
        ack1_o       = owner_q;
        err0_o       = ~owner_q & errFlag_q;
        err1_o       = owner_q & errFlag_q;
        lastServed_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to requester 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      lastServed_q <= 1'b1;
      mode_q       <= 1'b0;
      errFlag_q    <= 1'b0;
      waitCnt_q    <= 3'd0;
      operand_q    <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lastServed_q <= lastServed_d;
      mode_q       <= mode_d;
      errFlag_q    <= errFlag_d;
      waitCnt_q    <= waitCnt_d;
      operand_q    <= operand_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
    end
  end

endmodule

// File: tb/tb_ars_mixcol_arbiter.sv
// Directed bench for ars_mixcol_arbiter with a 4-cycle stub of the shared MixColumns unit.
// The stub returns operand XOR a mode-dependent word so results are easy to predict.
module tb_ars_mixcol_arbiter;

  localparam logic [31:0]  KFWD = 32'h0F0F_F0F0;
  localparam logic [31:0]  KINV = 32'h5A5A_A5A5;
  localparam logic [127:0] SPUR = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_i = 1'b0, req1_i = 1'b0;
  logic         dec0_i = 1'b0, dec1_i = 1'b0;
  logic [127:0] data0_i = '0, data1_i = '0;
  logic         ack0_o, ack1_o, err0_o, err1_o;
  logic [127:0] res0_o, res1_o;
  logic         busy_o, mc_start_o, mc_decrypt_o;
  logic [127:0] mc_data_o;
  logic         mc_ready_i;
  logic [127:0] mc_data_i;

  logic         modelOn = 1'b1;
  logic         spurReady = 1'b0;
  logic [3:0]   startPipe;
  logic [127:0] expRes0 = '0, expRes1 = '0;
  int           errors = 0;
  int           checks = 0;

  ars_mixcol_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_i(req0_i), .req1_i(req1_i), .dec0_i(dec0_i), .dec1_i(dec1_i),
    .data0_i(data0_i), .data1_i(data1_i),
    .ack0_o(ack0_o), .ack1_o(ack1_o), .err0_o(err0_o), .err1_o(err1_o),
    .res0_o(res0_o), .res1_o(res1_o), .busy_o(busy_o),
    .mc_start_o(mc_start_o), .mc_decrypt_o(mc_decrypt_o), .mc_data_o(mc_data_o),
    .mc_ready_i(mc_ready_i), .mc_data_i(mc_data_i)
  );

  always #5 clk = ~clk;

  // Stub unit: ready comes back in the fourth cycle after the start strobe is seen.
  always @(posedge clk or posedge reset) begin
    if (reset) startPipe <= '0;
    else       startPipe <= {startPipe[2:0], mc_start_o};
  end
  assign mc_ready_i = (modelOn & startPipe[3]) | spurReady;
  assign mc_data_i  = spurReady ? SPUR : (mc_data_o ^ {4{mc_decrypt_o ? KINV : KFWD}});

  function automatic logic [127:0] unitModel(input logic dec, input logic [127:0] data);
    return data ^ {4{dec ? KINV : KFWD}};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    req0_i = 1'b0;
    req1_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    expRes0 = '0;
    expRes1 = '0;
  endtask

  // One full operation for requester `who`; counts negedges from the edge that samples the request.
  task automatic applyStimulus(input int who, input logic dec, input logic [127:0] data,
                               input int expLat, input logic expErr, input logic [127:0] expRes,
                               input logic spurInDone);
    int   ackAt;
    logic holdOk;
    logic otherAck;
    ackAt = 0;
    holdOk = 1'b1;
    otherAck = 1'b0;
    if (who == 0) begin req0_i = 1'b1; dec0_i = dec; data0_i = data; end
    else          begin req1_i = 1'b1; dec1_i = dec; data1_i = data; end
    for (int c = 1; c <= 14 && ackAt == 0; c++) begin
      @(negedge clk);
      if (who == 0) data1_i = ~data1_i;
      else          data0_i = ~data0_i;
      if (c == 1) checkOutput("startStrobe", 128'(mc_start_o), 128'(1));
      if (c == 2) checkOutput("startOneCycle", 128'(mc_start_o), 128'(0));
      if (c < expLat && (mc_data_o !== data || mc_decrypt_o !== dec)) holdOk = 1'b0;
      if ((who == 0) ? ack1_o : ack0_o) otherAck = 1'b1;
      if ((who == 0) ? ack0_o : ack1_o) begin
        ackAt = c;
        checkOutput("ackLatency", 128'(ackAt), 128'(expLat));
        checkOutput("errFlag", 128'((who == 0) ? err0_o : err1_o), 128'(expErr));
        checkOutput("resValue", (who == 0) ? res0_o : res1_o, expRes);
        checkOutput("otherResHeld", (who == 0) ? res1_o : res0_o, (who == 0) ? expRes1 : expRes0);
        if (who == 0) begin req0_i = 1'b0; expRes0 = expRes; end
        else          begin req1_i = 1'b0; expRes1 = expRes; end
        if (spurInDone) spurReady = 1'b1;
      end
    end
    if (ackAt == 0) checkOutput("ackSeen", 128'(0), 128'(1));
    checkOutput("operandHeld", 128'(holdOk), 128'(1));
    checkOutput("noOtherAck", 128'(otherAck), 128'(0));
    @(negedge clk);
    spurReady = 1'b0;
    checkOutput("busyAfter", 128'(busy_o), 128'(0));
    checkOutput("noRepeatAck", 128'(ack0_o | ack1_o), 128'(0));
    checkOutput("resAfterDone", (who == 0) ? res0_o : res1_o, expRes);
  endtask

  task automatic spuriousIdle();
    logic bad;
    bad = 1'b0;
    spurReady = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (ack0_o || ack1_o || busy_o) bad = 1'b1;
    end
    spurReady = 1'b0;
    @(negedge clk);
    checkOutput("spurIdleNoAck", 128'(bad), 128'(0));
    checkOutput("spurIdleRes0", res0_o, expRes0);
    checkOutput("spurIdleRes1", res1_o, expRes1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int           k;
    int           who;
    logic         bothAck;
    logic         bad;
    logic [127:0] expVal;

    // Reset state
    @(negedge clk);
    checkOutput("rstBusy", 128'(busy_o), 128'(0));
    checkOutput("rstStart", 128'(mc_start_o), 128'(0));
    checkOutput("rstAcks", 128'({ack0_o, ack1_o, err0_o, err1_o}), 128'(0));
    checkOutput("rstRes0", res0_o, '0);
    checkOutput("rstRes1", res1_o, '0);
    checkOutput("rstOperand", mc_data_o, '0);
    checkOutput("rstMode", 128'(mc_decrypt_o), 128'(0));
    reset = 1'b0;
    @(negedge clk);

    // Single forward request from requester 0, result hand-computed against the stub
    applyStimulus(0, 1'b0, 128'hdbf201c6_13d309ff_13d309ff_13d309ff, 6, 1'b0,
                  128'hd4fdf136_1cdcf90f_1cdcf90f_1cdcf90f, 1'b0);
    spuriousIdle();

    // Both requesters held from reset release: grants alternate 0,1,0,1
    reset = 1'b1;
    modelOn = 1'b1;
    req0_i = 1'b1; dec0_i = 1'b0; data0_i = 128'h1000_0000_2000_0000_3000_0000_4000_0000;
    req1_i = 1'b1; dec1_i = 1'b1; data1_i = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    @(negedge clk);
    reset = 1'b0;
    expRes0 = '0;
    expRes1 = '0;
    k = 0;
    bothAck = 1'b0;
    for (int c = 1; c <= 40 && k < 4; c++) begin
      @(negedge clk);
      if (ack0_o && ack1_o) bothAck = 1'b1;
      if (ack0_o || ack1_o) begin
        who = ack1_o ? 1 : 0;
        checkOutput("rrOwner", 128'(who), 128'(k % 2));
        checkOutput("rrSpacing", 128'(c), 128'(6 + 7 * k));
        if (who == 0) begin
          expVal = unitModel(1'b0, data0_i);
          checkOutput("rrRes0", res0_o, expVal);
          checkOutput("rrRes1Held", res1_o, expRes1);
          expRes0 = expVal;
          data0_i = data0_i + 128'h1111;
        end else begin
          expVal = unitModel(1'b1, data1_i);
          checkOutput("rrRes1", res1_o, expVal);
          checkOutput("rrRes0Held", res0_o, expRes0);
          expRes1 = expVal;
          data1_i = data1_i + 128'h2222;
        end
        k++;
        if (k == 4) begin req0_i = 1'b0; req1_i = 1'b0; end
      end
    end
    checkOutput("rrCount", 128'(k), 128'(4));
    checkOutput("rrNoDoubleAck", 128'(bothAck), 128'(0));
    @(negedge clk);

    // Inverse request from requester 1 while data0 toggles every cycle
    applyStimulus(1, 1'b1, 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004, 6, 1'b0,
                  unitModel(1'b1, 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004), 1'b0);

    // Unit never answers: timeout with result untouched, then a normal operation
    pulseReset();
    modelOn = 1'b0;
    applyStimulus(0, 1'b0, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 10, 1'b1, '0, 1'b0);
    modelOn = 1'b1;
    applyStimulus(0, 1'b0, 128'h0000_0001_0000_0002_0000_0003_0000_0004, 6, 1'b0,
                  128'h0F0F_F0F1_0F0F_F0F2_0F0F_F0F3_0F0F_F0F4, 1'b0);

    // Reset two cycles after the start strobe aborts the operation silently
    req1_i = 1'b1; dec1_i = 1'b0; data1_i = 128'h7777_8888_7777_8888_7777_8888_7777_8888;
    @(negedge clk);
    checkOutput("abortStart", 128'(mc_start_o), 128'(1));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abortBusy", 128'(busy_o), 128'(0));
    checkOutput("abortStrobes", 128'({ack0_o, ack1_o, err0_o, err1_o, mc_start_o}), 128'(0));
    checkOutput("abortRes0", res0_o, '0);
    checkOutput("abortRes1", res1_o, '0);
    checkOutput("abortOperand", mc_data_o, '0);
    checkOutput("abortMode", 128'(mc_decrypt_o), 128'(0));
    req1_i = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ack0_o || ack1_o) bad = 1'b1;
    end
    checkOutput("abortNoAck", 128'(bad), 128'(0));
    reset = 1'b0;
    expRes0 = '0;
    expRes1 = '0;
    @(negedge clk);
    checkOutput("abortNoLateAck", 128'(ack0_o | ack1_o), 128'(0));

    // Fresh request after reset, with a spurious ready pulse during DONE
    applyStimulus(1, 1'b0, 128'h7777_8888_7777_8888_7777_8888_7777_8888, 6, 1'b0,
                  128'h7878_7878_7878_7878_7878_7878_7878_7878, 1'b1);
    spuriousIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
